// File: rtl/chipper_pkg.sv
// Shared flit format and router-port constants for the CHIPPER node.
package chipper_pkg;

    localparam int FLIT_W  = 10;
    localparam int COORD_W = 3;

    localparam int VLD_BIT = 9;
    localparam int AGE_HI  = 8;
    localparam int AGE_LO  = 6;
    localparam int DX_HI   = 5;
    localparam int DX_LO   = 3;
    localparam int DY_HI   = 2;
    localparam int DY_LO   = 0;

    localparam int EAST  = 0;
    localparam int WEST  = 1;
    localparam int NORTH = 2;
    localparam int SOUTH = 3;

    typedef logic [FLIT_W-1:0]  flit_t;
    typedef logic [COORD_W-1:0] coord_t;

    function automatic logic is_local(flit_t f, coord_t x, coord_t y);
        return f[VLD_BIT] && (f[DX_HI:DX_LO] == x) && (f[DY_HI:DY_LO] == y);
    endfunction

endpackage

// File: rtl/eject_fifo.sv
// Ejection buffer: circular FIFO of flits with occupancy count 0..FIFO_DEPTH.
module eject_fifo
    import chipper_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  flit_t                       din,
    input  logic                        pop,
    output flit_t                       dout,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    flit_t         r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    assign empty  = (r_count == '0);
    assign full   = (r_count == (AW+1)'(FIFO_DEPTH));
    assign count  = r_count;
    assign dout   = empty ? '0 : r_mem[r_rptr];
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ejector.sv
// Router ejection stage: round-robin picks one local-bound flit into the buffer.
// Optional EJECTOR_STATS_EN adds saturating eject/deflect counters.
module ejector
    import chipper_pkg::*;
#(
    parameter coord_t MY_X       = 3'd1,
    parameter coord_t MY_Y       = 3'd2,
    parameter int     FIFO_DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  flit_t eastad,
    input  flit_t westad,
    input  flit_t northad,
    input  flit_t southad,
    output flit_t ead,
    output flit_t wad,
    output flit_t nad,
    output flit_t sad,
    output flit_t localad,
    output logic  local_valid,
    input  logic  local_ready
`ifdef EJECTOR_STATS_EN
    ,
    output logic [15:0] eject_cnt,
    output logic [15:0] deflect_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    flit_t          w_in  [4];
    flit_t          r_out [4];
    logic [3:0]     w_lb;
    logic [1:0]     r_rr;
    logic [1:0]     w_idx;
    logic [1:0]     w_win;
    logic           w_any;
    logic           w_pop;
    logic           w_can;
    logic           w_eject;
    logic           w_deflect;
    logic [CW-1:0]  w_count;
    logic           w_full;
    logic           w_empty;

    assign w_in[EAST]  = eastad;
    assign w_in[WEST]  = westad;
    assign w_in[NORTH] = northad;
    assign w_in[SOUTH] = southad;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_lb[i] = is_local(w_in[i], MY_X, MY_Y);
        end
    end

    always_comb begin
        w_idx = '0;
        w_win = '0;
        w_any = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_rr + 2'(k);
            if (!w_any && w_lb[w_idx]) begin
                w_win = w_idx;
                w_any = 1'b1;
            end
        end
    end

    // A pop frees a slot in the same cycle, so a full buffer can still accept.
    assign w_pop     = local_valid && local_ready;
    assign w_can     = (w_count < CW'(FIFO_DEPTH)) || w_pop;
    assign w_eject   = w_any && w_can;
    assign w_deflect = w_any && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr <= '0;
            for (int i = 0; i < 4; i++) begin
                r_out[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_out[i] <= (w_eject && (w_win == 2'(i))) ? '0 : w_in[i];
            end
            if (w_eject) begin
                r_rr <= w_win + 2'd1;
            end
        end
    end

    assign ead = r_out[EAST];
    assign wad = r_out[WEST];
    assign nad = r_out[NORTH];
    assign sad = r_out[SOUTH];

    eject_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_eject),
        .din   (w_in[w_win]),
        .pop   (w_pop),
        .dout  (localad),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign local_valid = !w_empty;

`ifdef EJECTOR_STATS_EN
    logic [15:0] r_eject_cnt;
    logic [15:0] r_deflect_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_eject_cnt   <= '0;
            r_deflect_cnt <= '0;
        end else begin
            if (w_eject && (r_eject_cnt != 16'hFFFF)) begin
                r_eject_cnt <= r_eject_cnt + 1'b1;
            end
            if (w_deflect && (r_deflect_cnt != 16'hFFFF)) begin
                r_deflect_cnt <= r_deflect_cnt + 1'b1;
            end
        end
    end

    assign eject_cnt   = r_eject_cnt;
    assign deflect_cnt = r_deflect_cnt;
`endif

endmodule

// File: tb/tb_ejector.sv
// Randomized bench for ejector against a queue-based reference model.
module tb_ejector;
    import chipper_pkg::*;

    localparam int D = 4;

    logic  clk = 1'b0;
    logic  rst;
    flit_t ein, win, nin, sin;
    logic  rdy;
    flit_t ead, wad, nad, sad, localad;
    logic  local_valid;
`ifdef EJECTOR_STATS_EN
    logic [15:0] eject_cnt, deflect_cnt;
    int m_ecnt, m_dcnt;
`endif

    always #5 clk = ~clk;

    ejector #(
        .MY_X       (3'd1),
        .MY_Y       (3'd2),
        .FIFO_DEPTH (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .eastad      (ein),
        .westad      (win),
        .northad     (nin),
        .southad     (sin),
        .ead         (ead),
        .wad         (wad),
        .nad         (nad),
        .sad         (sad),
        .localad     (localad),
        .local_valid (local_valid),
        .local_ready (rdy)
`ifdef EJECTOR_STATS_EN
        ,
        .eject_cnt   (eject_cnt),
        .deflect_cnt (deflect_cnt)
`endif
    );

    flit_t mq[$];
    int    mrr;
    flit_t mout [4];
    int    passed = 0;
    int    total  = 0;

    function automatic bit is_loc(flit_t f);
        return f[9] && (f[5:3] == 3'd1) && (f[2:0] == 3'd2);
    endfunction

    function automatic flit_t lf(int age);
        return {1'b1, 3'(age), 3'd1, 3'd2};
    endfunction

    function automatic flit_t rnd();
        logic       v;
        logic [2:0] a, x, y;
        bit         loc;
        v   = ($urandom % 4) != 0;
        loc = ($urandom % 2) != 0;
        a   = 3'($urandom);
        x   = loc ? 3'd1 : 3'($urandom);
        y   = loc ? 3'd2 : 3'($urandom);
        return {v, a, x, y};
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input flit_t e, input flit_t w, input flit_t n,
                        input flit_t s, input logic r, input logic rs);
        flit_t in_f [4];
        bit    pop;
        bit    anyloc;
        int    wnr;
        int    idx;
        @(negedge clk);
        ein = e; win = w; nin = n; sin = s; rdy = r; rst = rs;
        in_f[0] = e; in_f[1] = w; in_f[2] = n; in_f[3] = s;
        if (rs) begin
            mq.delete();
            mrr = 0;
            for (int i = 0; i < 4; i++) mout[i] = '0;
`ifdef EJECTOR_STATS_EN
            m_ecnt = 0; m_dcnt = 0;
`endif
        end else begin
            pop    = (mq.size() > 0) && r;
            anyloc = 0;
            wnr    = -1;
            for (int i = 0; i < 4; i++) if (is_loc(in_f[i])) anyloc = 1;
            if (mq.size() < D || pop) begin
                for (int k = 0; k < 4; k++) begin
                    idx = (mrr + k) % 4;
                    if (wnr < 0 && is_loc(in_f[idx])) wnr = idx;
                end
            end
            for (int i = 0; i < 4; i++) mout[i] = in_f[i];
            if (pop) void'(mq.pop_front());
            if (wnr >= 0) begin
                mq.push_back(in_f[wnr]);
                mout[wnr] = '0;
                mrr = (wnr + 1) % 4;
`ifdef EJECTOR_STATS_EN
                if (m_ecnt < 16'hFFFF) m_ecnt++;
`endif
            end else if (anyloc) begin
`ifdef EJECTOR_STATS_EN
                if (m_dcnt < 16'hFFFF) m_dcnt++;
`endif
            end
        end
        @(posedge clk);
        #1;
        chk("ead", 16'(ead), 16'(mout[0]));
        chk("wad", 16'(wad), 16'(mout[1]));
        chk("nad", 16'(nad), 16'(mout[2]));
        chk("sad", 16'(sad), 16'(mout[3]));
        chk("localad", 16'(localad), 16'(mq.size() > 0 ? mq[0] : flit_t'(0)));
        chk("local_valid", 16'(local_valid), 16'(mq.size() > 0));
`ifdef EJECTOR_STATS_EN
        chk("eject_cnt", eject_cnt, 16'(m_ecnt));
        chk("deflect_cnt", deflect_cnt, 16'(m_dcnt));
`endif
    endtask

    initial begin
        int thr;
        ein = '0; win = '0; nin = '0; sin = '0; rdy = 1'b0; rst = 1'b1;
        mrr = 0;

        // reset, then idle inputs
        step('0, '0, '0, '0, 1'b0, 1'b1);
        step('0, '0, '0, '0, 1'b0, 1'b0);
        chk("idle_localad", 16'(localad), 16'h0);
        chk("idle_valid", 16'(local_valid), 16'h0);

        // single eject from east
        step(10'b1000001010, '0, '0, '0, 1'b1, 1'b0);
        chk("e1_ead", 16'(ead), 16'h0);
        chk("e1_localad", 16'(localad), 16'(10'b1000001010));
        chk("e1_valid", 16'(local_valid), 16'h1);

        // east + north with rr=0, then rr=1
        step('0, '0, '0, '0, 1'b1, 1'b1);
        step(lf(1), '0, lf(2), '0, 1'b1, 1'b0);
        chk("rr0_ead", 16'(ead), 16'h0);
        chk("rr0_nad", 16'(nad), 16'(lf(2)));
        chk("rr0_local", 16'(localad), 16'(lf(1)));
        step(lf(3), '0, lf(4), '0, 1'b1, 1'b0);
        chk("rr1_nad", 16'(nad), 16'h0);
        chk("rr1_ead", 16'(ead), 16'(lf(3)));
        chk("rr1_local", 16'(localad), 16'(lf(4)));

        // fill buffer, 5th deflected
        step('0, '0, '0, '0, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) step(lf(i), '0, '0, '0, 1'b0, 1'b0);
        chk("full_deflect_ead", 16'(ead), 16'(lf(5)));
        chk("full_head", 16'(localad), 16'(lf(1)));
`ifdef EJECTOR_STATS_EN
        chk("full_deflect_cnt", deflect_cnt, 16'd1);
`endif

        // push+pop on full buffer, then drain in order
        step(lf(6), '0, '0, '0, 1'b1, 1'b0);
        chk("pp_ead", 16'(ead), 16'h0);
        chk("pp_head", 16'(localad), 16'(lf(2)));
        step('0, '0, '0, '0, 1'b1, 1'b0);
        chk("drain3", 16'(localad), 16'(lf(3)));
        step('0, '0, '0, '0, 1'b1, 1'b0);
        chk("drain4", 16'(localad), 16'(lf(4)));
        step('0, '0, '0, '0, 1'b1, 1'b0);
        chk("drain6", 16'(localad), 16'(lf(6)));
        step('0, '0, '0, '0, 1'b1, 1'b0);
        chk("drain_empty", 16'(local_valid), 16'h0);

        // reset with 3 flits buffered
        for (int i = 1; i <= 3; i++) step('0, lf(i), '0, '0, 1'b0, 1'b0);
        step(lf(7), lf(7), lf(7), lf(7), 1'b1, 1'b1);
        chk("rst_valid", 16'(local_valid), 16'h0);
        chk("rst_localad", 16'(localad), 16'h0);
        chk("rst_wad", 16'(wad), 16'h0);
        step('0, '0, '0, lf(5), 1'b0, 1'b0);
        chk("post_rst_head", 16'(localad), 16'(lf(5)));

        // random traffic
        thr = 70;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) thr = $urandom_range(0, 100);
            step(rnd(), rnd(), rnd(), rnd(),
                 ($urandom % 100) < thr, ($urandom % 300) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ejector.md
EJECTOR -- requirements
Module: ejector

Interface
REQ-001 Parameter MY_X, default 3'd1: column of this router node.
REQ-002 Parameter MY_Y, default 3'd2: row of this router node.
REQ-003 Parameter FIFO_DEPTH, default 4: ejection buffer entries, power of two, at least 2.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 eastad / westad / northad / southad  input  10 each  arriving flit headers; input index 0 = east, 1 = west, 2 = north, 3 = south.
REQ-007 ead / wad / nad / sad  output  10 each  registered pass-through headers toward the injector stage; same index order as REQ-006.
REQ-008 localad  output  10  head-of-queue ejected flit to local PE.
REQ-009 local_valid  output  1  localad holds a flit.
REQ-010 local_ready  input  1  local PE accepts localad this cycle.
REQ-011 Header fields: [9] valid; [8:6] age; [5:3] dest_x; [2:0] dest_y.

Function
REQ-012 Input "local-bound" = valid bit high and dest_x == MY_X and dest_y == MY_Y.
REQ-013 Eject at most one flit per cycle; winner = first local-bound input scanning from round-robin pointer rr (2 bits) in index order, wrapping 3 to 0.
REQ-014 After an ejection, rr <= winner index + 1 (mod 4); no ejection: rr unchanged.
REQ-015 Ejection allowed only when the buffer can accept: count < FIFO_DEPTH, or count == FIFO_DEPTH with a pop this cycle (local_valid && local_ready).
REQ-016 Buffer full with no pop: no ejection; every local-bound flit passes through unchanged (deflected, re-routed downstream); rr unchanged.
REQ-017 Pass-through: each output = its input registered one cycle, except the ejected slot, which is driven 10'b0 (valid low), freeing it for injection.
REQ-018 Non-winning local-bound flits pass through unchanged in the same cycle.
REQ-019 Push and pop in the same cycle: count unchanged; FIFO order preserved.
REQ-020 Latency: flit ejected at edge N is visible on localad with local_valid high after edge N when buffer was empty; otherwise in FIFO order.
REQ-021 localad/local_valid held stable while local_valid && !local_ready.
REQ-022 Buffer empty: local_valid low, localad 10'b0.
REQ-023 Read/write pointers wrap modulo FIFO_DEPTH; count tracks 0..FIFO_DEPTH inclusive.

Reset
REQ-024 rst high at an edge: ead, wad, nad, sad, localad <= 10'b0; local_valid <= 0; rr <= 0; count and pointers <= 0.
REQ-025 Reset mid-operation discards buffered flits and in-flight pass-through headers, with no partial ejection; the first valid cycle after rst low behaves as from power-up.

Configuration
REQ-026 Macro EJECTOR_STATS_EN defined: add outputs eject_cnt (16 bits, increments per ejection) and deflect_cnt (16 bits, increments per cycle where REQ-016 deflects at least one local-bound flit); both saturate at 16'hFFFF and reset to 0.
REQ-027 EJECTOR_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

Structure
REQ-028 Shared package chipper_pkg holds: flit width 10; field positions of REQ-011; port index constants EAST=0, WEST=1, NORTH=2, SOUTH=3; coordinate width 3.
REQ-029 Ejection buffer is sub-module eject_fifo (parameter FIFO_DEPTH; push, din, pop, dout, count, full, empty); arbitration and pass-through stay in ejector.

Verification
REQ-030 Reset, then all inputs 10'b0 -> all outputs 0, local_valid 0.
REQ-031 eastad = 10'b1000001010 (to 1,2), others 0, local_ready 1 -> next cycle ead = 0, localad = 10'b1000001010, local_valid 1, rr = 1.
REQ-032 Local-bound flits on east and north together, rr = 0 -> east ejected, north passes to nad; repeat with rr = 1 -> north ejected first.
REQ-033 local_ready 0, feed 5 local-bound flits on successive cycles -> first 4 buffered; 5th passes through on its output port; with EJECTOR_STATS_EN, deflect_cnt = 1.
REQ-034 Full buffer, local_ready 1 and new local-bound flit in the same cycle -> pop and push both occur; count stays 4; order preserved.
REQ-035 rst asserted with 3 flits buffered -> next cycle local_valid 0, count 0, all outputs 0.
